// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access stage: width codes, load
// zero-extend bit position, FSM state type and an alignment helper.
package mem_access_pkg;

  localparam logic [1:0] MEM_WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF  = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD  = 2'b10;
  localparam logic [1:0] MEM_WIDTH_DWORD = 2'b11;

  localparam int ZERO_EXT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_WIDTH_BYTE: size_mask = 3'b000;
      MEM_WIDTH_HALF: size_mask = 3'b001;
      MEM_WIDTH_WORD: size_mask = 3'b011;
      default:        size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_aligner.sv
// Combinational byte-lane steering: store strobes/data shifted to the
// addressed lane, load data shifted down, truncated and extended.
// Lanes past byte 7 fall off the doubleword; accesses are never split.
module load_store_aligner
  import mem_access_pkg::*;
(
  input  logic [2:0]  off_i,
  input  logic [2:0]  width_i,
  input  logic [63:0] rs2_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdata_o,
  output logic [63:0] load_o
);

  logic [7:0]  base_strb;
  logic [63:0] shifted;
  logic        sext;

  // Lane select for stores and extraction/extension for loads.
  always_comb begin
    case (width_i[1:0])
      MEM_WIDTH_BYTE: base_strb = 8'h01;
      MEM_WIDTH_HALF: base_strb = 8'h03;
      MEM_WIDTH_WORD: base_strb = 8'h0F;
      default:        base_strb = 8'hFF;
    endcase
    wstrb_o = base_strb << off_i;
    wdata_o = rs2_i << {off_i, 3'b000};
    shifted = rdata_i >> {off_i, 3'b000};
    sext    = ~width_i[ZERO_EXT];
    case (width_i[1:0])
      MEM_WIDTH_BYTE: load_o = {{56{sext & shifted[7]}},  shifted[7:0]};
      MEM_WIDTH_HALF: load_o = {{48{sext & shifted[15]}}, shifted[15:0]};
      MEM_WIDTH_WORD: load_o = {{32{sext & shifted[31]}}, shifted[31:0]};
      default:        load_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage: performs the data-memory access for EX results over
// a req/ack bus, stalls upstream while a request is outstanding, and
// registers the result toward write-back. Non-memory ops pass in 1 cycle.
// Optional feature: MISALIGN_TRAP_EN adds misaligned_trap_out and turns
// misaligned accesses into a 1-cycle trap with no bus request.
module memory_access_stage
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] rs2_value_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  width_signal_in,
  input  logic        rd_write_signal_in,
  input  logic        read_signal_in,
  input  logic        write_signal_in,
  input  logic        wb_src_signal_in,
  input  logic        valid_instr_signal_in,
  input  logic        flush_signal_in,
  input  logic [63:0] mem_rdata_in,
  input  logic        mem_ack_in,
  output logic [63:0] mem_addr_out,
  output logic [63:0] mem_wdata_out,
  output logic [7:0]  mem_wstrb_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic        stall_signal_out,
  output logic [63:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_signal_out,
  output logic        valid_instr_signal_out,
  output logic        flush_signal_out,
`ifdef MISALIGN_TRAP_EN
  output logic        misaligned_trap_out,
`endif
  output logic        bus_error_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      wb_data_q, wb_data_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_write_q, rd_write_d;
  logic             valid_q, valid_d;
  logic             flush_q, bus_err_q;
  logic             mem_op, misalign, complete, timeout, trap, stall;
  logic [7:0]       lane_strb;
  logic [63:0]      load_data;

  assign mem_op = read_signal_in | write_signal_in;

`ifdef MISALIGN_TRAP_EN
  assign misalign = mem_op &&
                    ((alu_result_in[2:0] & size_mask(width_signal_in[1:0])) != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  load_store_aligner u_aligner (
    .off_i   (alu_result_in[2:0]),
    .width_i (width_signal_in),
    .rs2_i   (rs2_value_in),
    .rdata_i (mem_rdata_in),
    .wstrb_o (lane_strb),
    .wdata_o (mem_wdata_out),
    .load_o  (load_data)
  );

  // Access FSM: next state, stall, request and completion/timeout events.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    stall       = 1'b0;
    mem_req_out = 1'b0;
    complete    = 1'b0;
    timeout     = 1'b0;
    trap        = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misalign) begin
          stall   = 1'b1;
          state_d = BUSY;
        end else begin
          complete = 1'b1;
          trap     = misalign;
        end
      end
      BUSY: begin
        mem_req_out = 1'b1;
        if (mem_ack_in) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-back next values: result on completion, zero on timeout, bubble otherwise.
  always_comb begin
    wb_data_d  = wb_data_q;
    rd_d       = rd_q;
    rd_write_d = 1'b0;
    valid_d    = 1'b0;
    if (complete) begin
      wb_data_d  = (wb_src_signal_in && state_q == BUSY) ? load_data : alu_result_in;
      rd_d       = rd_in;
      rd_write_d = rd_write_signal_in & ~trap;
      valid_d    = valid_instr_signal_in;
    end else if (timeout) begin
      wb_data_d = '0;
    end
  end

  // State, timeout counter and write-back registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_data_q  <= '0;
      rd_q       <= '0;
      rd_write_q <= 1'b0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_data_q  <= wb_data_d;
      rd_q       <= rd_d;
      rd_write_q <= rd_write_d;
      valid_q    <= valid_d;
      flush_q    <= flush_signal_in;
      bus_err_q  <= timeout;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_q;

  // One-cycle trap flag for a rejected misaligned access.
  always_ff @(posedge clk_in) begin
    if (rst_in) trap_q <= 1'b0;
    else        trap_q <= trap;
  end

  assign misaligned_trap_out = trap_q;
`endif

  assign stall_signal_out       = stall;
  assign mem_addr_out           = {alu_result_in[63:3], 3'b000};
  assign mem_wstrb_out          = write_signal_in ? lane_strb : 8'h00;
  assign mem_we_out             = mem_req_out & write_signal_in;
  assign wb_data_out            = wb_data_q;
  assign rd_out                 = rd_q;
  assign rd_write_signal_out    = rd_write_q;
  assign valid_instr_signal_out = valid_q;
  assign flush_signal_out       = flush_q;
  assign bus_error_out          = bus_err_q;

endmodule
